// File: rtl/icache_nwa_pkg.sv
// Shared types and address-geometry helpers for the N-way instruction cache.
// Optional statistics counters are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, GAP, RESP} state_t;

  // Word-offset width inside a line.
  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Set-index width.
  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width: everything above byte offset, word offset and index.
  function automatic int tag_w(input int sets, input int line_words);
    return 32 - 2 - offset_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/icache_nwa_if.sv
// Processor-side and memory-side handshake bundles for icache_nwa.
// The cache is the slave of icache_proc_if and the master of icache_mem_if.
interface icache_proc_if;
  logic        proc_valid;
  logic        proc_ready;
  logic [31:0] proc_addr;
  logic [31:0] proc_rdata;

  modport master (output proc_valid, output proc_addr, input proc_ready, input proc_rdata);
  modport slave  (input proc_valid, input proc_addr, output proc_ready, output proc_rdata);
endinterface

interface icache_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;

  modport master (output mem_req_valid, output mem_req_addr, input mem_req_ready, input mem_req_rdata);
  modport slave  (input mem_req_valid, input mem_req_addr, output mem_req_ready, output mem_req_rdata);
endinterface

// File: rtl/icache_nwa_way.sv
// One cache way: valid bits (reset), tag and line data arrays (not reset),
// tag compare for the addressed set and a whole-line write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 6,
  parameter int TAG_W      = 22,
  parameter int BEAT_W     = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [INDEX_W-1:0]          index,
  input  logic [TAG_W-1:0]            tag,
  input  logic [BEAT_W-1:0]           word,
  output logic                        hit,
  output logic                        valid,
  output logic [31:0]                 rdata,
  input  logic                        wr_en,
  input  logic [32*LINE_WORDS-1:0]    wr_line
);

  logic [SETS-1:0]             valid_q;
  logic [TAG_W-1:0]            tag_q  [SETS];
  logic [32*LINE_WORDS-1:0]    data_q [SETS];

  // Valid bits: cleared by reset, set when a line is installed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else if (wr_en) valid_q[index] <= 1'b1;
  end

  // Tag and data storage, written only on line install.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= wr_line;
    end
  end

  assign valid = valid_q[index];
  assign hit   = valid_q[index] && (tag_q[index] == tag);
  assign rdata = data_q[index][32*word +: 32];

endmodule

// File: rtl/icache_nwa.sv
// N-way set-associative instruction cache with multi-word lines, sequential
// line fill and per-set round-robin replacement.
// Define ICACHE_STATS_EN to add saturating hit/miss counter ports.
module icache_nwa
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          resetn,
  icache_proc_if.slave  proc,
  icache_mem_if.master  mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses
`endif
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(SETS, LINE_WORDS);
  localparam int BEAT_W   = (OFFSET_W > 0) ? OFFSET_W : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t                   state, state_nxt;
  logic [31:0]              addr_q;
  logic [BEAT_W-1:0]        beat;
  logic [WAY_W-1:0]         victim_q, victim_nxt, rr_cur;
  logic [31:0]              fill_buf [LINE_WORDS];

  logic [INDEX_W-1:0]       idx;
  logic [TAG_W-1:0]         tag;
  logic [BEAT_W-1:0]        word;
  logic [31:0]              line_base;
  logic                     last_beat, install, hit_any;
  logic [31:0]              hit_data, resp_word;
  logic [WAYS-1:0]          hit_w, valid_w, wr_w;
  logic [31:0]              rdata_w [WAYS];
  logic [32*LINE_WORDS-1:0] line_wr;

  assign idx       = INDEX_W'(addr_q >> (2 + OFFSET_W));
  assign tag       = addr_q[31 -: TAG_W];
  assign word      = BEAT_W'((addr_q >> 2) & 32'(LINE_WORDS - 1));
  assign line_base = addr_q & ~32'(LINE_WORDS * 4 - 1);
  assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));
  assign install   = (state == FILL) && mem.mem_req_ready && last_beat;
  assign resp_word = line_wr[32*word +: 32];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .INDEX_W(INDEX_W),
      .TAG_W(TAG_W), .BEAT_W(BEAT_W)
    ) u_way (
      .clk(clk), .resetn(resetn), .index(idx), .tag(tag), .word(word),
      .hit(hit_w[w]), .valid(valid_w[w]), .rdata(rdata_w[w]),
      .wr_en(wr_w[w]), .wr_line(line_wr)
    );
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_ptr [SETS];

    // Per-set round-robin pointer, advanced on every line install.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
      end else if (install) begin
        rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;
      end
    end

    assign rr_cur = rr_ptr[idx];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // Hit detection, victim choice, line assembly and per-way write enables.
  always_comb begin
    hit_any    = |hit_w;
    hit_data   = '0;
    victim_nxt = rr_cur;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_w[w]) hit_data = hit_data | rdata_w[w];
      if (!valid_w[w]) victim_nxt = WAY_W'(w);
    end
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_wr[32*i +: 32] = (BEAT_W'(i) == beat) ? mem.mem_req_rdata : fill_buf[i];
    end
    for (int w = 0; w < WAYS; w++) begin
      wr_w[w] = install && (victim_q == WAY_W'(w));
    end
  end

  // Next-state logic of the lookup/fill controller.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (proc.proc_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit_any ? RESP : FILL;
      FILL:    if (mem.mem_req_ready) state_nxt = last_beat ? RESP : GAP;
      GAP:     state_nxt = FILL;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Registered handshake outputs, fill beat counter and latched victim.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proc.proc_ready   <= 1'b0;
      proc.proc_rdata   <= '0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= '0;
      beat              <= '0;
      victim_q          <= '0;
    end else begin
      proc.proc_ready   <= (state_nxt == RESP);
      mem.mem_req_valid <= (state_nxt == FILL);
      if (state == LOOKUP && !hit_any) begin
        mem.mem_req_addr <= line_base;
        beat             <= '0;
        victim_q         <= victim_nxt;
      end else if (state == GAP) begin
        mem.mem_req_addr <= line_base | (32'(beat) << 2);
      end else if (state == FILL && mem.mem_req_ready && !last_beat) begin
        beat <= beat + 1'b1;
      end
      if (state == LOOKUP && hit_any) proc.proc_rdata <= hit_data;
      else if (install)               proc.proc_rdata <= resp_word;
    end
  end

  // Request address capture and fill buffer (datapath, not reset).
  always_ff @(posedge clk) begin
    if (state == IDLE && proc.proc_valid) addr_q <= proc.proc_addr;
    if (state == FILL && mem.mem_req_ready) fill_buf[beat] <= mem.mem_req_rdata;
  end

`ifdef ICACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating hit/miss counters, stepped once per lookup.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit_any) stat_hits   <= sat_inc(stat_hits);
      else         stat_misses <= sat_inc(stat_misses);
    end
  end
`endif

endmodule

// File: tb/tb_icache_nwa.sv
// Directed self-checking bench for icache_nwa (WAYS=2, SETS=64, LINE_WORDS=4).
// Memory returns 32'hC0DE0000 | addr[15:0]; expected words are written out by hand.
module tb_icache_nwa;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  icache_proc_if pif();
  icache_mem_if  mif();

`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  icache_nwa #(.WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
    .clk(clk), .resetn(resetn), .proc(pif), .mem(mif)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cnt = 0;
  int start_cnt = 0;
  int gap_err = 0;
  int mem_wait = 0;
  logic [31:0] req_log [64];
  int start_cyc [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: answers each request after mem_wait extra cycles.
  initial begin
    int wait_left;
    bit prev_valid, prev_ready;
    wait_left = 0; prev_valid = 0; prev_ready = 0;
    mif.mem_req_ready = 1'b0;
    mif.mem_req_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mif.mem_req_ready = 1'b0;
      if (prev_ready && mif.mem_req_valid) gap_err++;
      if (mif.mem_req_valid && !prev_valid && start_cnt < 64) begin
        start_cyc[start_cnt] = cyc;
        start_cnt++;
      end
      prev_ready = 0;
      if (!mif.mem_req_valid || !resetn) begin
        wait_left = mem_wait;
      end else if (wait_left > 0) begin
        wait_left--;
      end else begin
        mif.mem_req_ready = 1'b1;
        mif.mem_req_rdata = 32'hC0DE_0000 | {16'h0, mif.mem_req_addr[15:0]};
        if (req_cnt < 64) req_log[req_cnt] = mif.mem_req_addr;
        req_cnt++;
        prev_ready = 1;
        wait_left = mem_wait;
      end
      prev_valid = mif.mem_req_valid;
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    pif.proc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] data, output int lat, output int nreq);
    int s;
    bit got;
    s = req_cnt; got = 0; lat = 0; data = '0;
    pif.proc_addr = a;
    pif.proc_valid = 1'b1;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (pif.proc_ready) begin
        got = 1;
        data = pif.proc_rdata;
      end
    end
    pif.proc_valid = 1'b0;
    nreq = req_cnt - s;
    check("fetch_done", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int lat, n, s0, r0, waited;
    pif.proc_valid = 1'b0;
    pif.proc_addr = '0;
    do_reset();

    // Reset state
    check("rst_proc_ready", {31'b0, pif.proc_ready}, 32'd0);
    check("rst_proc_rdata", pif.proc_rdata, 32'd0);
    check("rst_mem_valid", {31'b0, mif.mem_req_valid}, 32'd0);
    check("rst_mem_addr", mif.mem_req_addr, 32'd0);

    // Cold miss at 0x100
    r0 = req_cnt; s0 = start_cnt;
    fetch(32'h100, d, lat, n);
    check("cold_data", d, 32'hC0DE_0100);
    check("cold_lat", lat, 32'd9);
    check("cold_nreq", n, 32'd4);
    check("cold_a0", req_log[r0], 32'h100);
    check("cold_a1", req_log[r0+1], 32'h104);
    check("cold_a2", req_log[r0+2], 32'h108);
    check("cold_a3", req_log[r0+3], 32'h10C);
    for (int k = 0; k < 3; k++)
      check("cold_spacing", start_cyc[s0+k+1] - start_cyc[s0+k], 32'd2);
    @(posedge clk); #1;

    // Hits in the line just filled
    fetch(32'h108, d, lat, n);
    check("hit_data", d, 32'hC0DE_0108);
    check("hit_lat", lat, 32'd2);
    check("hit_nreq", n, 32'd0);
    @(posedge clk); #1;
    fetch(32'h10C, d, lat, n);
    check("hit_last_word", d, 32'hC0DE_010C);
    @(posedge clk); #1;

    // Miss on last word of a line with one wait cycle per beat
    mem_wait = 1;
    fetch(32'h20C, d, lat, n);
    check("slow_data", d, 32'hC0DE_020C);
    check("slow_lat", lat, 32'd13);
    check("slow_nreq", n, 32'd4);
    mem_wait = 0;
    @(posedge clk); #1;

    // Conflict: two lines in set 0, then both hit
    fetch(32'h000, d, lat, n); check("conf_000_nreq", n, 32'd4); check("conf_000_data", d, 32'hC0DE_0000);
    @(posedge clk); #1;
    fetch(32'h400, d, lat, n); check("conf_400_nreq", n, 32'd4); check("conf_400_data", d, 32'hC0DE_0400);
    @(posedge clk); #1;
    fetch(32'h004, d, lat, n); check("conf_000_hit", n, 32'd0); check("conf_004_data", d, 32'hC0DE_0004);
    @(posedge clk); #1;
    fetch(32'h408, d, lat, n); check("conf_400_hit", n, 32'd0); check("conf_408_data", d, 32'hC0DE_0408);
    @(posedge clk); #1;

    // Eviction from a clean start
    do_reset();
    fetch(32'h000, d, lat, n); check("ev_000_miss", n, 32'd4);
    @(posedge clk); #1;
    fetch(32'h400, d, lat, n); check("ev_400_miss", n, 32'd4);
    @(posedge clk); #1;
    fetch(32'h800, d, lat, n); check("ev_800_miss", n, 32'd4); check("ev_800_data", d, 32'hC0DE_0800);
    @(posedge clk); #1;
    fetch(32'h000, d, lat, n); check("ev_000_remiss", n, 32'd4);
    @(posedge clk); #1;
    fetch(32'h400, d, lat, n); check("ev_400_remiss", n, 32'd4);
    @(posedge clk); #1;
`ifdef ICACHE_STATS_EN
    check("stat_misses", stat_misses, 32'd5);
    check("stat_hits", stat_hits, 32'd0);
`endif
    fetch(32'h00C, d, lat, n); check("ev_000_hit", n, 32'd0); check("ev_00c_data", d, 32'hC0DE_000C);
    @(posedge clk); #1;
    fetch(32'h800, d, lat, n); check("ev_800_evicted", n, 32'd4);
    @(posedge clk); #1;
    do_reset();
`ifdef ICACHE_STATS_EN
    check("stat_misses_rst", stat_misses, 32'd0);
    check("stat_hits_rst", stat_hits, 32'd0);
`endif

    // Reset in the middle of a fill
    r0 = req_cnt; waited = 0;
    pif.proc_addr = 32'h300;
    pif.proc_valid = 1'b1;
    while (req_cnt - r0 < 2 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reached_2beats", req_cnt - r0, 32'd2);
    resetn = 1'b0;
    #1;
    check("abort_proc_ready", {31'b0, pif.proc_ready}, 32'd0);
    check("abort_proc_rdata", pif.proc_rdata, 32'd0);
    check("abort_mem_valid", {31'b0, mif.mem_req_valid}, 32'd0);
    check("abort_mem_addr", mif.mem_req_addr, 32'd0);
    pif.proc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    r0 = req_cnt;
    fetch(32'h300, d, lat, n);
    check("after_abort_nreq", n, 32'd4);
    check("after_abort_lat", lat, 32'd9);
    check("after_abort_data", d, 32'hC0DE_0300);
    check("after_abort_a0", req_log[r0], 32'h300);
    check("gap_violations", gap_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
